// File: rtl/rotate_image_scheduler.sv
// rotate_image_scheduler
//
// Frame-level sequencer for the CORDIC image-rotation datapath. Walks every
// destination pixel of an IMAGE_SIZE x IMAGE_SIZE frame in raster order
// (inverse mapping):
//   1. Hand the destination coordinate and the negated angle to the rotator.
//   2. Take the rotator's source coordinate.
//   3. Fetch that source pixel, or use BG_PIXEL when it is out of range.
//   4. Write the result into the destination frame RAM.
//
// Ports
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_start, i_abort       frame start (sampled in IDLE), synchronous abort
//   i_angle                signed rotation angle in degrees, latched at start
//   o_busy, o_done         frame in progress, one-cycle end-of-frame pulse
//   o_rot_*                rotator request (start pulse, H/V, negated angle)
//   i_rot_*                rotator response (source H/V, out-of-range, done)
//   o_src_rd, o_src_addr   source RAM read port
//   i_src_data             source RAM data, valid the cycle after o_src_rd
//   o_dst_we, o_dst_addr,
//   o_dst_data             destination RAM write port
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for i_start; angle latched and counters cleared on it
// ISSUE    | one-cycle rotator start for the current destination pixel
// WAIT_ROT | waiting for i_rot_done; captures source address and oor flag
// READ     | one-cycle source RAM read strobe
// WRITE    | one-cycle destination write, advance H/V
// FINISH   | one-cycle o_done pulse, back to IDLE
module rotate_image_scheduler #(
  parameter int                   IMAGE_SIZE     = 60,
  parameter int                   IMAGE_COOR_BIT = 6,
  parameter int                   ANG_WIDTH      = 9,
  parameter int                   ADDR_WIDTH     = 12,
  parameter int                   PIX_WIDTH      = 24,
  parameter logic [PIX_WIDTH-1:0] BG_PIXEL       = '0
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic                        i_abort,
  input  logic signed [ANG_WIDTH-1:0] i_angle,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_rot_start,
  output logic [IMAGE_COOR_BIT-1:0]   o_rot_H,
  output logic [IMAGE_COOR_BIT-1:0]   o_rot_V,
  output logic signed [ANG_WIDTH-1:0] o_rot_angle,
  input  logic [IMAGE_COOR_BIT-1:0]   i_rot_H,
  input  logic [IMAGE_COOR_BIT-1:0]   i_rot_V,
  input  logic                        i_rot_oor,
  input  logic                        i_rot_done,
  output logic                        o_src_rd,
  output logic [ADDR_WIDTH-1:0]       o_src_addr,
  input  logic [PIX_WIDTH-1:0]        i_src_data,
  output logic                        o_dst_we,
  output logic [ADDR_WIDTH-1:0]       o_dst_addr,
  output logic [PIX_WIDTH-1:0]        o_dst_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ROT,
    S_READ,
    S_WRITE,
    S_FINISH
  } state_t;

  localparam logic [IMAGE_COOR_BIT-1:0] LAST_COOR = IMAGE_COOR_BIT'(IMAGE_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0]     ROW_STEP  = ADDR_WIDTH'(IMAGE_SIZE);

  state_t                        state, state_nxt;
  logic [IMAGE_COOR_BIT-1:0]     h_q, v_q;
  logic [ADDR_WIDTH-1:0]         row_base_q;
  logic [ADDR_WIDTH-1:0]         src_addr_q;
  logic                          oor_q;
  logic signed [ANG_WIDTH-1:0]   angle_q;
  logic                          last_col, last_pix;

  assign last_col = (h_q == LAST_COOR);
  assign last_pix = last_col && (v_q == LAST_COOR);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Abort overrides every non-IDLE transition. Strobes that would start new
  // work (rotator start, source read, done) are suppressed in the abort cycle;
  // a write already in its WRITE cycle still completes.
  always_comb begin
    state_nxt   = state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_rot_start = 1'b0;
    o_src_rd    = 1'b0;
    o_dst_we    = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        o_busy      = 1'b1;
        o_rot_start = !i_abort;
        state_nxt   = S_WAIT_ROT;
      end
      S_WAIT_ROT: begin
        o_busy = 1'b1;
        if (i_rot_done) state_nxt = i_rot_oor ? S_WRITE : S_READ;
      end
      S_READ: begin
        o_busy    = 1'b1;
        o_src_rd  = !i_abort;
        state_nxt = S_WRITE;
      end
      S_WRITE: begin
        o_busy    = 1'b1;
        o_dst_we  = 1'b1;
        state_nxt = last_pix ? S_FINISH : S_ISSUE;
      end
      S_FINISH: begin
        o_done    = !i_abort;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (i_abort && (state != S_IDLE)) state_nxt = S_IDLE;
  end

  // The source coordinate is kept as a ready-made RAM address rather than
  // separate H/V, so the constant multiply sits on the capture path only.
  // The destination address uses a running row base instead of a multiply.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      h_q        <= '0;
      v_q        <= '0;
      row_base_q <= '0;
      src_addr_q <= '0;
      oor_q      <= 1'b0;
      angle_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            angle_q    <= i_angle;
            h_q        <= '0;
            v_q        <= '0;
            row_base_q <= '0;
          end
        end
        S_WAIT_ROT: begin
          if (i_rot_done && !i_abort) begin
            src_addr_q <= ADDR_WIDTH'(i_rot_V) * ROW_STEP + ADDR_WIDTH'(i_rot_H);
            oor_q      <= i_rot_oor;
          end
        end
        S_WRITE: begin
          if (last_col) begin
            h_q <= '0;
            if (last_pix) begin
              v_q        <= '0;
              row_base_q <= '0;
            end else begin
              v_q        <= v_q + 1'b1;
              row_base_q <= row_base_q + ROW_STEP;
            end
          end else begin
            h_q <= h_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rot_H     = h_q;
  assign o_rot_V     = v_q;
  assign o_rot_angle = -angle_q;
  assign o_src_addr  = src_addr_q;
  assign o_dst_addr  = row_base_q + ADDR_WIDTH'(h_q);
  // Write data is held at zero outside WRITE so the bus is quiet when idle.
  assign o_dst_data  = (state == S_WRITE) ? (oor_q ? BG_PIXEL : i_src_data) : '0;

endmodule

// File: tb/tb_rotate_image_scheduler.sv
`timescale 1ns/1ps
module tb_rotate_image_scheduler;

  localparam int          IMAGE_SIZE = 60;
  localparam int          COOR       = 6;
  localparam int          ANG        = 9;
  localparam int          AW         = 12;
  localparam int          PW         = 24;
  localparam logic [23:0] BG         = 24'hABCDEF;
  localparam int          NPIX       = IMAGE_SIZE * IMAGE_SIZE;
  localparam int          CTR        = IMAGE_SIZE / 2;

  logic                  i_clk = 1'b0;
  logic                  i_rst = 1'b1;
  logic                  i_start = 1'b0;
  logic                  i_abort = 1'b0;
  logic signed [ANG-1:0] i_angle = '0;
  logic                  o_busy, o_done, o_rot_start;
  logic [COOR-1:0]       o_rot_H, o_rot_V;
  logic signed [ANG-1:0] o_rot_angle;
  logic [COOR-1:0]       i_rot_H = '0;
  logic [COOR-1:0]       i_rot_V = '0;
  logic                  i_rot_oor = 1'b0;
  logic                  i_rot_done = 1'b0;
  logic                  o_src_rd;
  logic [AW-1:0]         o_src_addr;
  logic [PW-1:0]         i_src_data = '0;
  logic                  o_dst_we;
  logic [AW-1:0]         o_dst_addr;
  logic [PW-1:0]         o_dst_data;

  rotate_image_scheduler #(
    .IMAGE_SIZE(IMAGE_SIZE), .IMAGE_COOR_BIT(COOR), .ANG_WIDTH(ANG),
    .ADDR_WIDTH(AW), .PIX_WIDTH(PW), .BG_PIXEL(BG)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .i_angle(i_angle), .o_busy(o_busy), .o_done(o_done),
    .o_rot_start(o_rot_start), .o_rot_H(o_rot_H), .o_rot_V(o_rot_V),
    .o_rot_angle(o_rot_angle), .i_rot_H(i_rot_H), .i_rot_V(i_rot_V),
    .i_rot_oor(i_rot_oor), .i_rot_done(i_rot_done), .o_src_rd(o_src_rd),
    .o_src_addr(o_src_addr), .i_src_data(i_src_data), .o_dst_we(o_dst_we),
    .o_dst_addr(o_dst_addr), .o_dst_data(o_dst_data)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { int addr; int data; bit oor; } exp_t;

  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t sb_q[$];
  int   cur_angle = 0, exp_h = 0, exp_v = 0;
  int   src_rd_cnt = 0, wr_cnt = 0, done_cnt = 0, rot_cnt = 0;
  int   last_wr_addr = -1;
  int   lat_min = 1, lat_max = 1;
  bit   rot_pending = 0;
  int   rot_wait = 0, rs_h = 0, rs_v = 0;
  bit   rs_oor = 0;
  logic [PW-1:0] dst_mem [NPIX];

  // Inverse-mapping reference: rotate (h,v) about the frame centre by ang,
  // using 8-bit fixed-point cos/sin, rounded to nearest.
  function automatic void rot_map(input int h, input int v, input int ang,
                                  output int sh, output int sv, output bit oor);
    int c, s, dx, dy;
    case (ang)
      90:      begin c = 0;   s = 256;  end
      -90:     begin c = 0;   s = -256; end
      45:      begin c = 181; s = 181;  end
      -45:     begin c = 181; s = -181; end
      default: begin c = 256; s = 0;    end
    endcase
    dx  = h - CTR;
    dy  = v - CTR;
    sh  = ((dx * c - dy * s + 128) >>> 8) + CTR;
    sv  = ((dx * s + dy * c + 128) >>> 8) + CTR;
    oor = (sh < 0) || (sh >= IMAGE_SIZE) || (sv < 0) || (sv >= IMAGE_SIZE);
  endfunction

  // Source RAM: src[a] = a, one-cycle read latency, junk when not read.
  always @(posedge i_clk) begin
    i_src_data <= o_src_rd ? PW'(o_src_addr) : 24'h5A5A5A;
  end

  // Behavioural rotator: responds L cycles after its start, using the
  // coordinate and angle the DUT actually presents.
  always @(negedge i_clk) begin
    int sh, sv;
    bit oor;
    if (i_rst) begin
      rot_pending = 0;
      i_rot_done  = 1'b0;
    end else begin
      i_rot_done = 1'b0;
      if (rot_pending) begin
        if (rot_wait == 0) begin
          i_rot_done  = 1'b1;
          i_rot_H     = COOR'(rs_h);
          i_rot_V     = COOR'(rs_v);
          i_rot_oor   = rs_oor;
          rot_pending = 0;
        end else begin
          rot_wait--;
        end
      end
      if (o_rot_start) begin
        rot_map(int'(o_rot_H), int'(o_rot_V), int'(o_rot_angle), sh, sv, oor);
        rs_h = sh; rs_v = sv; rs_oor = oor;
        rot_pending = 1;
        rot_wait = int'($urandom_range(lat_max, lat_min)) - 1;
      end
    end
  end

  // Scoreboard: expectation pushed at each rotator request, popped at write.
  always @(negedge i_clk) begin
    int   sh, sv;
    bit   oor;
    exp_t e;
    if (!i_rst) begin
      if (o_rot_start) begin
        rot_cnt++;
        tests_run++;
        if (o_rot_H !== COOR'(exp_h) || o_rot_V !== COOR'(exp_v) ||
            o_rot_angle !== ANG'(-cur_angle)) begin
          tests_failed++;
          $display("FAIL rot_issue: got H=%0d V=%0d ang=%0d, expected H=%0d V=%0d ang=%0d",
                   o_rot_H, o_rot_V, o_rot_angle, exp_h, exp_v, -cur_angle);
        end
        rot_map(exp_h, exp_v, -cur_angle, sh, sv, oor);
        e.addr = exp_v * IMAGE_SIZE + exp_h;
        e.oor  = oor;
        e.data = oor ? int'(BG) : (sv * IMAGE_SIZE + sh);
        sb_q.push_back(e);
        if (exp_h == IMAGE_SIZE - 1) begin exp_h = 0; exp_v++; end
        else exp_h++;
      end
      if (o_src_rd) src_rd_cnt++;
      if (o_dst_we) begin
        wr_cnt++;
        last_wr_addr = int'(o_dst_addr);
        if (int'(o_dst_addr) < NPIX) dst_mem[o_dst_addr] = o_dst_data;
        tests_run++;
        if (sb_q.size() == 0) begin
          tests_failed++;
          $display("FAIL dst_write: unexpected write addr=%0d data=%h", o_dst_addr, o_dst_data);
        end else begin
          e = sb_q.pop_front();
          if (o_dst_addr !== AW'(e.addr) || o_dst_data !== PW'(e.data) ||
              src_rd_cnt != (e.oor ? 0 : 1)) begin
            tests_failed++;
            $display("FAIL dst_write: got addr=%0d data=%h reads=%0d, expected addr=%0d data=%h reads=%0d",
                     o_dst_addr, o_dst_data, src_rd_cnt, e.addr, PW'(e.data), e.oor ? 0 : 1);
          end
        end
        src_rd_cnt = 0;
      end
      if (o_done) begin
        done_cnt++;
        tests_run++;
        if (o_busy !== 1'b0) begin
          tests_failed++;
          $display("FAIL done_busy: o_busy=%b during o_done, expected 0", o_busy);
        end
      end
      if ((int'(o_rot_start) + int'(o_src_rd) + int'(o_dst_we)) > 1) begin
        tests_failed++;
        $display("FAIL strobe_excl: rot_start=%b src_rd=%b dst_we=%b, expected at most one",
                 o_rot_start, o_src_rd, o_dst_we);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_frame(input int ang, input int lmin, input int lmax);
    @(negedge i_clk);
    cur_angle = ang; lat_min = lmin; lat_max = lmax;
    exp_h = 0; exp_v = 0; src_rd_cnt = 0;
    sb_q.delete();
    i_angle = ANG'(ang);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    tests_run++;
    if (o_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_busy: o_busy=%b the cycle after start, expected 1", o_busy);
    end
  endtask

  // cyc counts cycles after the start sample; ISSUE of pixel 0 is cycle 1.
  task automatic wait_done(input int budget, output int cyc, output bit ok);
    ok = 0;
    cyc = 1;
    while (cyc < budget) begin
      @(negedge i_clk);
      cyc++;
      if (o_done === 1'b1) begin ok = 1; break; end
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL done_timeout: no o_done within %0d cycles", budget);
    end
  endtask

  task automatic wait_rot_count(input int target, input int budget);
    int n = 0;
    while ((rot_cnt < target) && (n < budget)) begin
      @(negedge i_clk); #1;
      n++;
    end
    tests_run++;
    if (rot_cnt < target) begin
      tests_failed++;
      $display("FAIL rot_count_timeout: rot_cnt=%0d, expected %0d", rot_cnt, target);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    tests_run++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_status: busy=%b done=%b, expected 0 0", o_busy, o_done);
    end
    tests_run++;
    if ({o_rot_start, o_src_rd, o_dst_we} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_strobes: got %b, expected 000", {o_rot_start, o_src_rd, o_dst_we});
    end
    tests_run++;
    if (o_rot_H !== '0 || o_rot_V !== '0 || o_rot_angle !== '0) begin
      tests_failed++;
      $display("FAIL reset_rot: H=%0d V=%0d ang=%0d, expected 0", o_rot_H, o_rot_V, o_rot_angle);
    end
    tests_run++;
    if (o_src_addr !== '0 || o_dst_addr !== '0 || o_dst_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_addr: src=%0d dst=%0d data=%h, expected 0", o_src_addr, o_dst_addr, o_dst_data);
    end
    i_rst = 1'b0;
    repeat (4) @(negedge i_clk);
    tests_run++;
    if (o_busy !== 1'b0 || rot_cnt != 0) begin
      tests_failed++;
      $display("FAIL idle_hold: busy=%b rot_cnt=%0d without start, expected 0 0", o_busy, rot_cnt);
    end
  endtask

  task automatic test_identity();
    int cyc, d0, w0, bad;
    bit ok;
    d0 = done_cnt; w0 = wr_cnt;
    start_frame(0, 1, 1);
    wait_done(20000, cyc, ok);
    tests_run++;
    if (cyc > 4 * NPIX + 2 || cyc < 4 * NPIX) begin
      tests_failed++;
      $display("FAIL identity_latency: %0d cycles, expected %0d..%0d", cyc, 4 * NPIX, 4 * NPIX + 2);
    end
    repeat (2) @(negedge i_clk);
    tests_run++;
    if (done_cnt - d0 != 1 || wr_cnt - w0 != NPIX || sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL identity_counts: done=%0d writes=%0d left=%0d, expected 1 %0d 0",
               done_cnt - d0, wr_cnt - w0, sb_q.size(), NPIX);
    end
    bad = 0;
    for (int a = 0; a < NPIX; a++) if (dst_mem[a] !== PW'(a)) bad++;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL identity_frame: %0d pixels differ from src[a]=a, expected 0", bad);
    end
  endtask

  task automatic test_rotation_start_ignored();
    int cyc, d0, w0, rc;
    bit ok;
    d0 = done_cnt; w0 = wr_cnt;
    start_frame(90, 1, 2);
    repeat (800) @(negedge i_clk);
    i_angle = ANG'(-90);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    wait_done(25000, cyc, ok);
    repeat (2) @(negedge i_clk);
    rc = rot_cnt;
    tests_run++;
    if (done_cnt - d0 != 1 || wr_cnt - w0 != NPIX || sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL rot90_counts: done=%0d writes=%0d left=%0d, expected 1 %0d 0",
               done_cnt - d0, wr_cnt - w0, sb_q.size(), NPIX);
    end
    tests_run++;
    if (dst_mem[0] !== BG || dst_mem[1] !== PW'(3540)) begin
      tests_failed++;
      $display("FAIL rot90_pixels: dst[0]=%h dst[1]=%h, expected %h %h", dst_mem[0], dst_mem[1], BG, PW'(3540));
    end
    repeat (10) @(negedge i_clk);
    tests_run++;
    if (o_busy !== 1'b0 || rot_cnt != rc || done_cnt - d0 != 1) begin
      tests_failed++;
      $display("FAIL no_restart: busy=%b new_issues=%0d done=%0d, expected 0 0 1", o_busy, rot_cnt - rc, done_cnt - d0);
    end
  endtask

  task automatic test_abort_then_frame();
    int cyc, d0, w0, r0, wa;
    bit ok;
    d0 = done_cnt; w0 = wr_cnt; r0 = rot_cnt;
    start_frame(0, 1, 1);
    wait_rot_count(r0 + 101, 1000);
    @(negedge i_clk);
    i_abort = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0;
    wa = wr_cnt;
    tests_run++;
    if (o_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_idle: o_busy=%b after abort, expected 0", o_busy);
    end
    repeat (20) @(negedge i_clk);
    tests_run++;
    if (wr_cnt != wa || wr_cnt - w0 != 100 || done_cnt != d0 || rot_cnt - r0 != 101 || sb_q.size() != 1) begin
      tests_failed++;
      $display("FAIL abort_quiet: writes=%0d done=%0d issues=%0d left=%0d, expected 100 0 101 1",
               wr_cnt - w0, done_cnt - d0, rot_cnt - r0, sb_q.size());
    end
    sb_q.delete();
    d0 = done_cnt;
    start_frame(45, 1, 2);
    wait_done(25000, cyc, ok);
    repeat (2) @(negedge i_clk);
    tests_run++;
    if (done_cnt - d0 != 1 || sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL rot45_counts: done=%0d left=%0d, expected 1 0", done_cnt - d0, sb_q.size());
    end
    tests_run++;
    if (dst_mem[0] !== BG || dst_mem[59] !== BG || dst_mem[3540] !== BG || dst_mem[3599] !== BG) begin
      tests_failed++;
      $display("FAIL rot45_corners: %h %h %h %h, expected %h", dst_mem[0], dst_mem[59], dst_mem[3540], dst_mem[3599], BG);
    end
    tests_run++;
    if (dst_mem[1830] !== PW'(1830)) begin
      tests_failed++;
      $display("FAIL rot45_centre: %h, expected %h", dst_mem[1830], PW'(1830));
    end
  endtask

  task automatic test_reset_mid();
    int r0, w0, n;
    r0 = rot_cnt;
    start_frame(0, 2, 2);
    wait_rot_count(r0 + 5, 1000);
    @(negedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    tests_run++;
    if ({o_busy, o_done, o_rot_start, o_src_rd, o_dst_we} !== 5'b0 ||
        o_rot_H !== '0 || o_rot_V !== '0 || o_rot_angle !== '0 ||
        o_src_addr !== '0 || o_dst_addr !== '0 || o_dst_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid: busy=%b H=%0d V=%0d src=%0d dst=%0d data=%h, expected all 0",
               o_busy, o_rot_H, o_rot_V, o_src_addr, o_dst_addr, o_dst_data);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    sb_q.delete();
    w0 = wr_cnt;
    start_frame(0, 1, 1);
    n = 0;
    while ((wr_cnt == w0) && (n < 100)) begin
      @(negedge i_clk); #1;
      n++;
    end
    tests_run++;
    if (wr_cnt == w0 || last_wr_addr != 0) begin
      tests_failed++;
      $display("FAIL reset_restart: first write addr=%0d writes=%0d, expected addr 0", last_wr_addr, wr_cnt - w0);
    end
    repeat (10) @(negedge i_clk);
    i_abort = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0;
    repeat (3) @(negedge i_clk);
    sb_q.delete();
  endtask

  initial begin
    test_reset();
    test_identity();
    test_rotation_start_ignored();
    test_abort_then_frame();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
